// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response capture buffer.
//   PUF_RESP_WIDTH_DEF / PUF_RESP_DEPTH_DEF : default word width and buffer depth
//   puf_word_t                              : default-width response word
//   puf_cnt_width()                         : width of an occupancy counter for a given depth
package puf_pkg;

  localparam int unsigned PUF_RESP_WIDTH_DEF = 16;
  localparam int unsigned PUF_RESP_DEPTH_DEF = 8;

  typedef logic [PUF_RESP_WIDTH_DEF-1:0] puf_word_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned puf_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/puf_resp_buf_mem.sv
// WIDTH x DEPTH response storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module puf_resp_buf_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/puf_resp_capture_buf.sv
// First-word-fall-through capture buffer for PUF response words.
// Captures data_in on ld, pops on rd_en, flushes on clr; reports occupancy and a sticky
// overflow flag for words dropped while full.
// Optional feature macro PUF_RESP_STABLE_CHECK_EN: accumulates in unstable_mask every bit that
// differed between successive accepted captures; when undefined unstable_mask is tied to 0.
//   clk, rst (async, active high)
//   data_in, ld     : capture word / strobe
//   clr             : synchronous flush of buffer and status
//   rd_en           : pop request, effective only while valid
//   data_out        : head word, 0 when empty
//   valid, full     : non-empty / count == DEPTH
//   count           : occupancy
//   overflow        : sticky dropped-word flag
//   unstable_mask   : bits seen to change between captures
module puf_resp_capture_buf
  import puf_pkg::*;
#(
  parameter int unsigned WIDTH = PUF_RESP_WIDTH_DEF,
  parameter int unsigned DEPTH = PUF_RESP_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              ld,
  input  logic                              clr,
  input  logic                              rd_en,
  output logic [WIDTH-1:0]                  data_out,
  output logic                              valid,
  output logic                              full,
  output logic [puf_cnt_width(DEPTH)-1:0]   count,
  output logic                              overflow,
  output logic [WIDTH-1:0]                  unstable_mask
);

  localparam int unsigned CntW = puf_cnt_width(DEPTH);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop, push, drop, mem_we;
  logic [WIDTH-1:0] rdata;

  assign valid = (count_q != '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign pop   = rd_en & valid;
  // A full buffer still accepts a word when the head is leaving in the same cycle.
  assign push  = ld & (~full | pop);
  assign drop  = ld & full & ~pop;
  assign mem_we = push & ~clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  puf_resp_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign data_out = valid ? rdata : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef PUF_RESP_STABLE_CHECK_EN
  logic [WIDTH-1:0] last_word_q, last_word_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             first_seen_q, first_seen_d;

  always_comb begin
    last_word_d  = last_word_q;
    mask_d       = mask_q;
    first_seen_d = first_seen_q;
    if (clr) begin
      last_word_d  = '0;
      mask_d       = '0;
      first_seen_d = 1'b0;
    end else if (push) begin
      // The first capture has nothing to compare against.
      if (first_seen_q) mask_d = mask_q | (last_word_q ^ data_in);
      last_word_d  = data_in;
      first_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word_q  <= '0;
      mask_q       <= '0;
      first_seen_q <= 1'b0;
    end else begin
      last_word_q  <= last_word_d;
      mask_q       <= mask_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign unstable_mask = mask_q;
`else
  assign unstable_mask = '0;
`endif

endmodule

// File: tb/tb_puf_resp_capture_buf.sv
module tb_puf_resp_capture_buf;
  import puf_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    data_in;
  logic            ld, clr, rd_en;
  logic [W-1:0]    data_out;
  logic            valid, full, overflow;
  logic [3:0]      count;
  logic [W-1:0]    unstable_mask;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of words the buffer should hold, plus sticky overflow.
  puf_word_t mq[$];
  logic      m_ovf = 1'b0;

  always #5 clk = ~clk;

  puf_resp_capture_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .ld            (ld),
    .clr           (clr),
    .rd_en         (rd_en),
    .data_out      (data_out),
    .valid         (valid),
    .full          (full),
    .count         (count),
    .overflow      (overflow),
    .unstable_mask (unstable_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status and head checks against the model, done away from the clock edge.
  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".valid"}, 32'(valid), 32'(mq.size() != 0));
    check({tag, ".full"}, 32'(full), 32'(mq.size() == D));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".head"}, 32'(data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
  endtask

  // One clock cycle of stimulus; called just after a falling edge.
  task automatic cycle(input logic l, input logic [W-1:0] d, input logic r, input logic c,
                       input string tag);
    bit was_full, do_pop;
    puf_word_t exp;
    ld = l; data_in = d; rd_en = r; clr = c;
    #1;
    was_full = (mq.size() == D);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      do_pop = r && (mq.size() != 0);
      if (do_pop) begin
        exp = mq.pop_front();
        check({tag, ".pop"}, 32'(data_out), 32'(exp));
      end
      if (l && (!was_full || do_pop)) mq.push_back(d);
      else if (l) m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0; rd_en = 1'b0; clr = 1'b0;
    check_status(tag);
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; clr = 1'b0; rd_en = 1'b0; data_in = '0;
    #12;
    check_status("reset");
    check("reset.mask", 32'(unstable_mask), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0, "idle");

    // Fill past capacity: ninth word must be dropped.
    for (int i = 1; i <= 9; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, "fill");
    check("fill.full", 32'(full), 32'h1);
    check("fill.ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    check("drain.valid", 32'(valid), 32'h0);

    // Empty with simultaneous ld and rd_en: write only.
    cycle(1'b1, 16'h1234, 1'b1, 1'b0, "empty_ldrd");
    check("empty_ldrd.dout", 32'(data_out), 32'h1234);
    cycle(1'b0, '0, 1'b1, 1'b0, "empty_pop");

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(16'h0100 + i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 16'hAAAA, 1'b1, 1'b0, "full_ldrd");
    check("full_ldrd.count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain2");

    // Interleaved push/pop across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, W'(16'h3000 + i * 7), 1'b0, 1'b0, "wrap_push");
      cycle(1'b0, '0, 1'b1, 1'b0, "wrap_pop");
    end

    // Clear beats ld/rd_en; overflow is still set from the fill above.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(16'h5000 + i), 1'b0, 1'b0, "pre_clr");
    check("pre_clr.ovf", 32'(overflow), 32'h1);
    cycle(1'b1, 16'h5555, 1'b1, 1'b1, "clr");
    cycle(1'b1, 16'h7777, 1'b0, 1'b0, "post_clr_push");
    cycle(1'b0, '0, 1'b1, 1'b0, "post_clr_pop");

    // Stability mask.
    cycle(1'b0, '0, 1'b0, 1'b1, "stab_clr");
    cycle(1'b1, 16'h00F0, 1'b0, 1'b0, "stab0");
    cycle(1'b1, 16'h00F1, 1'b0, 1'b0, "stab1");
    cycle(1'b1, 16'h80F1, 1'b0, 1'b0, "stab2");
`ifdef PUF_RESP_STABLE_CHECK_EN
    check("stab.mask", 32'(unstable_mask), 32'h8001);
`else
    check("stab.mask", 32'(unstable_mask), 32'h0);
`endif
    cycle(1'b0, '0, 1'b0, 1'b1, "stab_clr2");
    check("stab.mask_clr", 32'(unstable_mask), 32'h0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'h9000 + i), 1'b0, 1'b0, "burst");
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_status("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0, "resume");
    cycle(1'b0, '0, 1'b1, 1'b0, "resume_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_resp_capture_buf.md
# puf_resp_capture_buf

Parametrised, clocked successor to the single-bit load/clear latch. It captures WIDTH-bit PUF response words on a load strobe into a DEPTH-entry first-word-fall-through buffer. It supports synchronous clear, a read handshake, and occupancy/overflow status. It sits between the PUF response sampler and the readout/host interface, decoupling capture bursts from readout.

## Interface
Parameters:
- WIDTH, 16, response word width (≥1)
- DEPTH, 8, buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  WIDTH  response word to capture
- ld  in  1  capture strobe; one word per cycle while high
- clr  in  1  synchronous flush of buffer and status
- rd_en  in  1  pop request; effective only when valid=1
- data_out  out  WIDTH  head word (FWFT); 0 when empty
- valid  out  1  buffer non-empty
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: a ld was dropped
- unstable_mask  out  WIDTH  bits that differed between successive captures

## Operation
- Reset (async, rst=1):
  - wr_ptr=rd_ptr=0, count=0, valid=0, full=0, overflow=0, unstable_mask=0, data_out=0.
  - Storage array is not reset.
- Priority per cycle: rst > clr > (ld, rd_en).
- clr=1: same state as reset (except storage). ld and rd_en are ignored that cycle.
- Pop: rd_en=1 and valid=1 → rd_ptr+1 (mod DEPTH), count−1.
- Push: ld=1 and accept → mem[wr_ptr]<=data_in, wr_ptr+1 (mod DEPTH), count+1.
  - accept = !full OR (rd_en AND valid).
  - Full with simultaneous pop → push and pop both happen, count unchanged.
- ld=1 while full without pop: word dropped, overflow<=1. overflow stays set until clr or rst.
- Empty with ld and rd_en: write happens, rd_en ignored, count 0→1.
- Pointers wrap at DEPTH. count never exceeds DEPTH or goes below 0.
- data_out = mem[rd_ptr] when valid, else 0.

## Timing
- Write latency 1: ld sampled at edge k → valid=1 and data_out=word after edge k.
- Pop: data_out advances to the next entry after the edge where rd_en&&valid.
- valid, full, count, overflow are registered or derived from registered count. No combinational path from ld to any output.
- data_out has a combinational path from rd_ptr/mem only, not from the inputs.
- rst asserted mid-burst: outputs go to reset values immediately, without waiting for clk. Operation resumes on the first edge after deassertion.

## Configuration
- Macro: PUF_RESP_STABLE_CHECK_EN.
- Defined:
  - Adds last_word (WIDTH) and first_seen (1) registers.
  - On each accepted push: if first_seen, unstable_mask |= last_word ^ data_in. Then last_word<=data_in and first_seen<=1.
  - Dropped words do not update either register.
  - clr/rst clear unstable_mask, last_word and first_seen.
- Undefined: no extra registers. unstable_mask is tied to 0, and the port list is unchanged.

## Structure
- Package puf_pkg:
  - PUF_RESP_WIDTH_DEF=16, PUF_RESP_DEPTH_DEF=8.
  - typedef puf_word_t (logic [PUF_RESP_WIDTH_DEF-1:0]).
  - function for the count width.
- Sub-module puf_resp_buf_mem: WIDTH×DEPTH storage with a write port and an async read port. The top level holds the pointers, count, status and stability logic.

## Test plan
- Reset and idle:
  - rst pulse between edges → all outputs 0 immediately.
  - 10 idle cycles → valid=0, count=0.
- Fill and overflow (WIDTH=16, DEPTH=8):
  - ld 9 words 0x0001..0x0009 back-to-back → full=1 and count=8 after the 8th.
  - 9th dropped, overflow=1.
  - Pop 8 → data_out sequence 0x0001..0x0008, then valid=0.
- Simultaneous push/pop:
  - When full: ld 0xAAAA with rd_en → count stays 8, head advances, 0xAAAA read last.
  - When empty: ld+rd_en → count=1, data_out=word.
- Wrap-around: 20 push/pop pairs interleaved → read order matches write order across pointer wrap, count≤1 throughout.
- Clear priority:
  - clr with ld and rd_en high at count=5, overflow=1 → count=0, overflow=0, valid=0.
  - The ld word is not stored.
- Stability (macro defined): push 0x00F0, 0x00F1, 0x80F1 → unstable_mask=0x8001. After clr → 0. With macro undefined → always 0.
